arm_multicycle_controller: RTL
==============================

// Module: arm_multicycle_controller
// PURPOSE
//   Control unit at the far end of the datapath<->controller interface: consumes ToControler
//   (Instr[31:20]), Rd and the ALU Flags. Drives every datapath control strobe for a multicycle
//   ARM subset: LDR/STR imm, ADD/SUB/AND/ORR/EOR/CMP reg+imm, B.
//   Holds the main FSM, the NZCV status register and the condition-check logic.
// PARAMETERS
//   RESET_STATE  4'd0  encoding loaded on reset (FETCH)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low; 0 clears state to FETCH and NZCV to 0
//   ToControler  in   12  Instr[31:20]: Cond[11:8], Op[7:6], Funct[5:0] (I=5, cmd=4:1, S/L=0)
//   Rd           in   4   Instr[15:12]
//   Flags        in   4   ALU result flags {N,Z,C,V}, valid in EXECUTER/EXECUTEI
//   PCWrite      out  1   load PC
//   AdrSrc       out  1   0=PC, 1=ALUOut to memory address
//   MemWrite     out  1   data-memory write
//   IRWrite      out  1   load instruction register
//   RegWrite     out  1   register-file write
//   ALUScrA      out  1   0=RD1, 1=PC
//   ALUScrB      out  2   00=RD2, 01=ExtImm, 10=const 4
//   ResultSrc    out  2   00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUControl   out  4   0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR
//   ImmScr       out  2   = Op (00 dp-imm8, 01 mem-imm12, 10 branch-imm24)
//   RegSrc       out  2   [0]=1 when Op=10 (Rn<-PC); [1]=1 when Op=01 & L=0 (RA2<-Rd)
// BEHAVIOUR
//   States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
//   FETCH->DECODE. DECODE: Op=01->MEMADR; Op=00&I=0->EXECUTER; Op=00&I=1->EXECUTEI; Op=10->BRANCH;
//   Op=11->UNKNOWN. MEMADR: L=1->MEMREAD, L=0->MEMWRITE. MEMREAD->MEMWB. EXECUTER/EXECUTEI->ALUWB.
//   MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN->FETCH.
//   Outputs are Moore functions of state (plus gated CondEx/Rd); unlisted strobes are 0.
//   Unlisted muxes hold value 0.
//   FETCH:  AdrSrc=0 IRWrite=1 PCWrite=1 ALUScrA=1 ALUScrB=10 ADD ResultSrc=10.
//   DECODE: ALUScrA=1 ALUScrB=10 ADD ResultSrc=10; CondEx register loaded here.
//   MEMADR: ALUScrA=0 ALUScrB=01 ADD. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01 RegWrite=CondEx.
//   MEMWRITE: AdrSrc=1 MemWrite=CondEx. EXECUTER: ALUScrB=00. EXECUTEI: ALUScrB=01.
//   Both EXECUTE states: ALUControl from cmd: 0100 ADD, 0010/1010 SUB, 0000 AND, 1100 ORR, 0001 EOR.
//   Any other cmd -> ADD, no writes.
//   ALUWB: ResultSrc=00; RegWrite=CondEx&!CMP; PCWrite=CondEx&(Rd==15)&!CMP.
//   BRANCH: ALUScrA=0 ALUScrB=01 ADD ResultSrc=10 PCWrite=CondEx.
//   UNKNOWN: no strobes.
//   NZCV: updated on the clock edge leaving EXECUTER/EXECUTEI when S=1 (CMP always) and CondEx=1.
//   N,Z load for all ops; C,V load only for ADD/SUB/CMP. Never updated in other states.
//   CondEx: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V,
//   LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0. Uses the registered NZCV,
//   evaluated in DECODE; holds through the instruction.
//   Reset values (reset=0, any time incl. mid-instruction): state FETCH, NZCV 0000; outputs
//   at FETCH values.
//   Release: first edge with reset=1 completes FETCH.
//   CPI: LDR 5, STR 4, data-proc 4, B 3, undefined 3.
// TESTING
//   Reset asserted in MEMREAD -> same cycle state=FETCH, IRWrite=1, MemWrite=0, NZCV=0000.
//   ADD r1,r2,#5 (ToControler=12'hE28) -> 4 cycles: FETCH,DECODE,EXECUTEI,ALUWB.
//     ALUWB: RegWrite=1, ResultSrc=00.
//   SUBS (12'hE05) with Flags=4'b0100 in EXECUTER -> NZCV=0100. Then BEQ (12'h0A0) -> BRANCH PCWrite=1.
//     Same BEQ with Z=0 -> PCWrite=0, RegSrc=01.
//   STR (12'hE58), Rd=3 -> MEMADR ALUScrB=01, MEMWRITE AdrSrc=1 MemWrite=1; RegSrc=10. No RegWrite.
//   LDR (12'hE59) -> MEMREAD AdrSrc=1, then MEMWB ResultSrc=01 RegWrite=1; 5 cycles total.
//   ADD with Rd=15, Cond=AL -> ALUWB PCWrite=1 and RegWrite=1. Op=11 -> UNKNOWN, all strobes 0.

Source files
------------

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM, NZCV status register and
// condition check, driving every datapath strobe as a Moore function of state.
module arm_multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ToControler,
  input  logic [3:0]  Rd,
  input  logic [3:0]  Flags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUScrA,
  output logic [1:0]  ALUScrB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmScr,
  output logic [1:0]  RegSrc
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  nzcv_r;
  logic        cond_ex_r;

  logic [3:0]  cond_s, cmd_s, alu_ctl_s;
  logic [1:0]  op_s;
  logic        i_s, sl_s, cmd_ok_s, cmp_s, arith_s, in_exec_s;

  assign cond_s    = ToControler[11:8];
  assign op_s      = ToControler[7:6];
  assign i_s       = ToControler[5];
  assign cmd_s     = ToControler[4:1];
  assign sl_s      = ToControler[0];
  assign in_exec_s = (state_r == EXECUTER) || (state_r == EXECUTEI);

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, ok;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: ok = z;
      4'b0001: ok = !z;
      4'b0010: ok = c;
      4'b0011: ok = !c;
      4'b0100: ok = n;
      4'b0101: ok = !n;
      4'b0110: ok = v;
      4'b0111: ok = !v;
      4'b1000: ok = c & !z;
      4'b1001: ok = !c | z;
      4'b1010: ok = (n == v);
      4'b1011: ok = (n != v);
      4'b1100: ok = !z & (n == v);
      4'b1101: ok = z | (n != v);
      4'b1110: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU command decode; unsupported commands fall back to ADD and suppress all writes
  always_comb begin
    alu_ctl_s = 4'b0000;
    cmd_ok_s  = 1'b1;
    cmp_s     = 1'b0;
    arith_s   = 1'b0;
    case (cmd_s)
      4'b0100: arith_s = 1'b1;
      4'b0010: begin alu_ctl_s = 4'b0001; arith_s = 1'b1; end
      4'b1010: begin alu_ctl_s = 4'b0001; arith_s = 1'b1; cmp_s = 1'b1; end
      4'b0000: alu_ctl_s = 4'b0010;
      4'b1100: alu_ctl_s = 4'b0011;
      4'b0001: alu_ctl_s = 4'b0100;
      default: cmd_ok_s = 1'b0;
    endcase
  end

  // State, condition latch and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= state_t'(RESET_STATE);
      nzcv_r    <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == DECODE) cond_ex_r <= cond_check(cond_s, nzcv_r);
      if (in_exec_s && cond_ex_r && cmd_ok_s && (sl_s || cmp_s)) begin
        nzcv_r[3:2] <= Flags[3:2];
        if (arith_s) nzcv_r[1:0] <= Flags[1:0];
      end
    end
  end

  // Next state and Moore strobes
  always_comb begin
    state_nxt_s = FETCH;
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUScrA     = 1'b0;
    ALUScrB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUControl  = 4'b0000;
    case (state_r)
      FETCH: begin
        state_nxt_s = DECODE;
        IRWrite     = 1'b1;
        PCWrite     = 1'b1;
        ALUScrA     = 1'b1;
        ALUScrB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      DECODE: begin
        ALUScrA   = 1'b1;
        ALUScrB   = 2'b10;
        ResultSrc = 2'b10;
        case (op_s)
          2'b00:   state_nxt_s = i_s ? EXECUTEI : EXECUTER;
          2'b01:   state_nxt_s = MEMADR;
          2'b10:   state_nxt_s = BRANCH;
          default: state_nxt_s = UNKNOWN;
        endcase
      end
      MEMADR: begin
        state_nxt_s = sl_s ? MEMREAD : MEMWRITE;
        ALUScrB     = 2'b01;
      end
      MEMREAD: begin
        state_nxt_s = MEMWB;
        AdrSrc      = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_r;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_r;
      end
      EXECUTER: begin
        state_nxt_s = ALUWB;
        ALUControl  = alu_ctl_s;
      end
      EXECUTEI: begin
        state_nxt_s = ALUWB;
        ALUScrB     = 2'b01;
        ALUControl  = alu_ctl_s;
      end
      ALUWB: begin
        RegWrite = cond_ex_r & cmd_ok_s & !cmp_s;
        PCWrite  = cond_ex_r & cmd_ok_s & !cmp_s & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUScrB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_r;
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  assign ImmScr = op_s;
  assign RegSrc = {(op_s == 2'b01) & !sl_s, (op_s == 2'b10)};

endmodule
